// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers and MTHI/MTLO-style direct writes.
// A started operation holds busy for a fixed, per-class number of cycles, then commits its result.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        hilo_write,
    input  logic        hilo_sel,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic [31:0] a_q, b_q;
    op_t         op_q;

    logic        accept, done, direct_write;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, uquot, urem;
    logic [31:0] res_hi, res_lo;

    assign busy         = (state == BUSY);
    assign accept       = (state == IDLE) && start;
    assign done         = (state == BUSY) && (cnt == 5'd1);
    assign direct_write = (state == IDLE) && !start && hilo_write;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = op[1] ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                cnt_next = cnt - 5'd1;
                if (cnt == 5'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed multiply is an unsigned 64-bit multiply of sign-extended operands.
    always_comb begin
        mul_a   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        mul_b   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = mul_a * mul_b;
    end

    // Signed divide works on magnitudes; -2^31 / -1 then naturally yields 0x80000000 rem 0.
    always_comb begin
        a_neg = (op_q == OP_DIV) && a_q[31];
        b_neg = (op_q == OP_DIV) && b_q[31];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        uquot = a_mag / b_mag;
        urem  = a_mag % b_mag;
    end

    always_comb begin
        res_hi = product[63:32];
        res_lo = product[31:0];
        if (op_q == OP_DIV || op_q == OP_DIVU) begin
            if (b_q == 32'd0) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = a_neg ? -urem : urem;
                res_lo = (a_neg ^ b_neg) ? -uquot : uquot;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MULT;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                a_q  <= num1;
                b_q  <= num2;
                op_q <= op_t'(op);
            end
            if (done) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (direct_write) begin
                if (hilo_sel) hi <= write_data;
                else          lo <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus randomized ops against an arithmetic model.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] num1, num2, write_data;
    logic [1:0]  op;
    logic        start, hilo_write, hilo_sel;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi, exp_lo;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t vecs [7] = '{
        '{2'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA},
        '{2'd1, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA},
        '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{2'd3, 32'd7,         32'd2,         32'd1,         32'd3},
        '{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF},
        '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000},
        '{2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF}
    };

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .num1(num1), .num2(num2), .op(op), .start(start),
        .hilo_write(hilo_write), .hilo_sel(hilo_sel), .write_data(write_data),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the instruction semantics, using 64-bit integers.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'd0;
        l = 32'd0;
        case (o)
            2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    h = r[31:0]; l = q[31:0];
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Launch an op from the low clock phase and count busy cycles; returns at the first idle sample.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input bit with_write, output int cycles);
        num1 = a; num2 = b; op = o; start = 1'b1;
        hilo_write = with_write; hilo_sel = 1'($urandom); write_data = $urandom;
        @(negedge clk);
        start = 1'b0; hilo_write = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            cycles++;
            if (noise) begin
                num1 = $urandom; num2 = $urandom; op = 2'($urandom);
                start = 1'($urandom); hilo_write = 1'($urandom);
                hilo_sel = 1'($urandom); write_data = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0; hilo_write = 1'b0;
        model(o, a, b, exp_hi, exp_lo);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hilo_write = 1'b0; hilo_sel = 1'b0;
        num1 = '0; num2 = '0; op = '0; write_data = '0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        #2 rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_directed();
        int cyc, want;
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, 1'b0, 1'b0, cyc);
            want = vecs[i].o[1] ? DIV_N : MULT_N;
            total++; if (cyc !== want) begin bad++; $display("FAIL directed%0d_cycles: got %0d want %0d", i, cyc, want); end
            total++; if (hi !== vecs[i].h) begin bad++; $display("FAIL directed%0d_hi: got %h want %h", i, hi, vecs[i].h); end
            total++; if (lo !== vecs[i].l) begin bad++; $display("FAIL directed%0d_lo: got %h want %h", i, lo, vecs[i].l); end
        end
    endtask

    task automatic test_hilo_write();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            hilo_write = 1'b1; hilo_sel = (i % 2 == 0); write_data = d;
            @(negedge clk);
            hilo_write = 1'b0;
            if (i % 2 == 0) exp_hi = d; else exp_lo = d;
            total++; if (hi !== exp_hi) begin bad++; $display("FAIL write%0d_hi: got %h want %h", i, hi, exp_hi); end
            total++; if (lo !== exp_lo) begin bad++; $display("FAIL write%0d_lo: got %h want %h", i, lo, exp_lo); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL write%0d_busy: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_start_wins();
        int cyc;
        run_op(2'd1, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1, cyc);
        total++; if (cyc !== MULT_N) begin bad++; $display("FAIL startwins_cycles: got %0d want %0d", cyc, MULT_N); end
        total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL startwins_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, cyc);
        total++; if (cyc !== MULT_N) begin bad++; $display("FAIL ignore_cycles: got %0d want %0d", cyc, MULT_N); end
        total++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin bad++; $display("FAIL ignore_hilo: got %h_%h want ffffffff_fffffffa", hi, lo); end
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, cyc);
        total++; if (cyc !== DIV_N) begin bad++; $display("FAIL ignore_div_cycles: got %0d want %0d", cyc, DIV_N); end
        total++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL ignore_div_hilo: got %h_%h want ffffffff_fffffffd", hi, lo); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        num1 = 32'd1000; num2 = 32'd7; op = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
        #1 rst = 1'b0;
        run_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b0, cyc);
        total++; if (cyc !== MULT_N) begin bad++; $display("FAIL abort_mult_cycles: got %0d want %0d", cyc, MULT_N); end
        total++; if ({hi, lo} !== {32'd0, 32'd42}) begin bad++; $display("FAIL abort_mult_hilo: got %h_%h want 0_2a", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(2'd0, $urandom, $urandom, 1'b0, 1'b0, cyc);
        total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL b2b_first_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
        run_op(2'd3, 32'd100, 32'd9, 1'b0, 1'b0, cyc);
        total++; if (cyc !== DIV_N) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, DIV_N); end
        total++; if ({hi, lo} !== {32'd1, 32'd11}) begin bad++; $display("FAIL b2b_hilo: got %h_%h want 1_b", hi, lo); end
    endtask

    task automatic test_random();
        int cyc, want;
        logic [1:0] o;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                d = $urandom;
                hilo_write = 1'b1; hilo_sel = 1'($urandom); write_data = d;
                if (hilo_sel) exp_hi = d; else exp_lo = d;
                @(negedge clk);
                hilo_write = 1'b0;
            end
            o = 2'($urandom);
            run_op(o, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), cyc);
            want = o[1] ? DIV_N : MULT_N;
            total++; if (cyc !== want) begin bad++; $display("FAIL rand%0d_cycles: got %0d want %0d", i, cyc, want); end
            total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL rand%0d_hilo op=%0d: got %h_%h want %h_%h", i, o, hi, lo, exp_hi, exp_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hilo_write();
        test_start_wins();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
